regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits.
REQ-002 Parameter DEPTH, default 8, entry count; power of two, >= 2; AW = clog2(DEPTH).
REQ-003 Parameter NRD, default 2, number of read ports, >= 1.
REQ-004 Parameter ZERO_REG, default 0; when 1, entry 0 is hardwired to zero.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 clr_n  input  1  reset, synchronous and active-low.
REQ-007 rd_addr  input  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-008 rd_data  output  NRD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-009 rd_busy  output  NRD  per-port flag: addressed entry has a pending reserved write.
REQ-010 wr_en  input  1  write-back enable.
REQ-011 wr_addr  input  AW  write-back address.
REQ-012 wr_data  input  DATA_W  write-back data.
REQ-013 rsv_en  input  1  issue stage reserves a destination entry (marks it pending).
REQ-014 rsv_addr  input  AW  entry to reserve.
REQ-015 flush_req  input  1  single-cycle request to zero every entry sequentially.
REQ-016 flush_busy  output  1  high while a flush is in progress.
REQ-017 flush_done  output  1  one-cycle pulse when the flush completes.

Function
REQ-018 Reads are combinational, zero latency, on all NRD ports independently.
REQ-019 In IDLE, wr_en=1 with wr_addr == rd_addr[i] drives wr_data onto port i in the same cycle (bypass); otherwise the port returns the stored entry.
REQ-020 In IDLE, wr_en=1 writes wr_data to entry wr_addr at the clock edge and clears its scoreboard bit.
REQ-021 In IDLE, rsv_en=1 sets the scoreboard bit of entry rsv_addr at the clock edge.
REQ-022 rsv_en and wr_en to the same address in the same cycle: data is written and the scoreboard bit ends SET (the new producer wins).
REQ-023 rd_busy[i] = scoreboard[rd_addr[i]] AND NOT (wr_en AND wr_addr == rd_addr[i] AND state == IDLE).
REQ-024 ZERO_REG=1: reads of entry 0 return 0, rd_busy is 0, and writes and reservations to entry 0 are dropped; the bypass never applies to entry 0.
REQ-025 The FSM has two states, IDLE and FLUSH; flush_req=1 in IDLE moves it to FLUSH and loads flush counter = 0.
REQ-026 In FLUSH, each cycle zeroes entry[counter] and clears its scoreboard bit, then increments counter; after entry DEPTH-1 the FSM returns to IDLE.
REQ-027 A flush occupies exactly DEPTH cycles; flush_busy = (state == FLUSH); flush_done is registered high for the one cycle after the last entry is cleared.
REQ-028 In FLUSH, wr_en, rsv_en and flush_req are ignored; reads return stored contents with no bypass.
REQ-029 flush_req coinciding with wr_en or rsv_en in IDLE: the write or reservation is applied in that cycle and the flush begins the next cycle.
REQ-030 The flush counter is AW bits wide; its wrap from DEPTH-1 to 0 coincides with the return to IDLE.

Reset
REQ-031 clr_n=0 at a rising edge clears all entries and all scoreboard bits, forces state IDLE, counter 0 and flush_done 0; this overrides any write, reservation or flush in progress.
REQ-032 While clr_n=0, flush_busy=0 after the first edge, and rd_data reflects the cleared entries plus the IDLE bypass.

Structure
REQ-033 Package regfile_pkg holds the state enum (IDLE, FLUSH) and the address-width function.
REQ-034 The scoreboard is a sub-module regfile_scoreboard with set, clear, flush-clear and reset inputs and a DEPTH-bit output vector.

Verification
REQ-035 Reset, then write 0xDEADBEEF to entry 3 with rd_addr0=3 in the same cycle -> rd_data0=0xDEADBEEF that cycle, and still 0xDEADBEEF next cycle with wr_en=0.
REQ-036 rsv_en to entry 5; next cycle rd_addr1=5 -> rd_busy1=1; write entry 5 = 0x12 -> rd_busy1=0 in the same cycle, and 0 afterwards.
REQ-037 rsv_en and wr_en to entry 2 in the same cycle with data 0x7 -> entry 2 = 0x7 and rd_busy=1 for entry 2 afterwards.
REQ-038 Fill all entries with i+1, then pulse flush_req -> flush_busy high 8 cycles, entries zeroed in order 0..7, flush_done pulses once, and a write attempted during the flush is lost.
REQ-039 ZERO_REG=1: write 0xFFFF to entry 0 and reserve entry 0 -> reads of entry 0 return 0 and rd_busy=0.
REQ-040 Assert clr_n=0 at flush cycle 3 -> next cycle IDLE, flush_busy=0, no flush_done pulse, all entries 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
//   state_e : controller state (IDLE = normal operation, FLUSH = sequential clear)
//   addr_w  : address width for a given entry count
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Address width for DEPTH entries; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle between the issue/write-back logic and the register file.
//   rd_addr/rd_data/rd_busy : NRD packed read ports (port i at [i*W +: W])
//   wr_en/wr_addr/wr_data   : write-back port
//   rsv_en/rsv_addr         : destination reservation from issue
//   flush_req/busy/done     : sequential clear control and status
// master = requester side, slave = register file side.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 3,
  parameter int NRD    = 2
);

  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_addr;
  logic                  flush_req;
  logic                  flush_busy;
  logic                  flush_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush_req,
    input  rd_data, rd_busy, flush_busy, flush_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush_req,
    output rd_data, rd_busy, flush_busy, flush_done
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per entry, set when a producer is
// issued, cleared on write-back or by the flush sweep.
//   clk, clr_n_i            : clock, synchronous active-low clear
//   set_i/set_addr_i        : mark entry pending
//   clr_i/clr_addr_i        : write-back completed for entry
//   flush_clr_i/flush_addr_i: flush sweep clearing entry
//   sb_o                    : DEPTH-bit pending vector
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             clr_n_i,
  input  logic             set_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_i,
  input  logic [AW-1:0]    clr_addr_i,
  input  logic             flush_clr_i,
  input  logic [AW-1:0]    flush_addr_i,
  output logic [DEPTH-1:0] sb_o
);

  logic [DEPTH-1:0] sb_q, sb_d;

  // Set is applied last so a same-cycle reservation beats the
  // write-back clear: the newer producer owns the entry.
  always_comb begin
    sb_d = sb_q;
    if (clr_i)       sb_d[clr_addr_i]   = 1'b0;
    if (flush_clr_i) sb_d[flush_addr_i] = 1'b0;
    if (set_i)       sb_d[set_addr_i]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clr_n_i) sb_q <= '0;
    else          sb_q <= sb_d;
  end

  assign sb_o = sb_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-back bypass, per-entry pending scoreboard and
// a sequential flush that zeroes one entry per cycle.
//   clk   : sole clock, rising edge
//   clr_n : synchronous active-low clear of entries, scoreboard and FSM
//   bus   : regfile_sb_if slave (read ports, write-back, reserve, flush)
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 0,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic         clk,
  input  logic         clr_n,
  regfile_sb_if.slave  bus
);

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  sb;

  logic idle;
  logic wr_ok;
  logic rsv_ok;
  logic flush_clr;

  assign idle = (state_q == IDLE);

  // Entry 0 swallows writes and reservations when it is hardwired to zero.
  assign wr_ok     = idle && bus.wr_en &&
                     !((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign rsv_ok    = idle && bus.rsv_en &&
                     !((ZERO_REG != 0) && (bus.rsv_addr == '0));
  assign flush_clr = !idle;

  // NOTE: every variable gets a default before any branch, so no path
  // through this block leaves a value held and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        // Counter wraps to 0 on the same edge that returns to IDLE.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every
  // register samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the storage array is reset explicitly because a clear must leave
  // every entry architecturally zero; this keeps it in flops, not RAM.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end else if (flush_clr) begin
      mem_q[cnt_q] <= '0;
    end
  end

  regfile_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
    .clk          (clk),
    .clr_n_i      (clr_n),
    .set_i        (rsv_ok),
    .set_addr_i   (bus.rsv_addr),
    .clr_i        (wr_ok),
    .clr_addr_i   (bus.wr_addr),
    .flush_clr_i  (flush_clr),
    .flush_addr_i (cnt_q),
    .sb_o         (sb)
  );

  // Read ports: hardwired zero first, then same-cycle write-back bypass
  // (IDLE only), otherwise the stored entry. A bypassed port is never busy
  // because its producer is completing right now.
  always_comb begin
    logic [AW-1:0] ra;
    logic          zero;
    logic          hit;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra          = '0;
    zero        = 1'b0;
    hit         = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra   = bus.rd_addr[i*AW +: AW];
      zero = (ZERO_REG != 0) && (ra == '0);
      hit  = idle && bus.wr_en && (bus.wr_addr == ra) && !zero;
      if (zero)     bus.rd_data[i*DATA_W +: DATA_W] = '0;
      else if (hit) bus.rd_data[i*DATA_W +: DATA_W] = bus.wr_data;
      else          bus.rd_data[i*DATA_W +: DATA_W] = mem_q[ra];
      bus.rd_busy[i] = sb[ra] && !hit && !zero;
    end
  end

  assign bus.flush_busy = !idle;
  assign bus.flush_done = done_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios on a ZERO_REG=0
// instance and a ZERO_REG=1 instance, plus randomized traffic compared
// against an array-based reference model of the register file.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int NRD    = 2;
  localparam int AW     = 3;

  logic clk = 1'b0;
  logic clr_n;
  always #10 clk = ~clk;

  regfile_sb_if #(.DATA_W(DATA_W), .AW(AW), .NRD(NRD)) a_if ();
  regfile_sb_if #(.DATA_W(DATA_W), .AW(AW), .NRD(NRD)) b_if ();

  regfile_sb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(0)) dut_a (
    .clk(clk), .clr_n(clr_n), .bus(a_if)
  );
  regfile_sb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(1)) dut_b (
    .clk(clk), .clr_n(clr_n), .bus(b_if)
  );

  // Reference model of dut_a: contents, pending bits, flush progress.
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_sb  [DEPTH];
  bit                m_flushing;
  int                m_fidx;
  bit                m_done;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [DATA_W-1:0] exp_data(input int a);
    if (!m_flushing && a_if.wr_en && int'(a_if.wr_addr) == a) return a_if.wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (!m_flushing && a_if.wr_en && int'(a_if.wr_addr) == a) return 1'b0;
    return m_sb[a];
  endfunction

  task automatic model_step();
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_sb[i]  = 1'b0;
      end
      m_flushing = 1'b0;
      m_fidx     = 0;
      m_done     = 1'b0;
    end else if (m_flushing) begin
      m_mem[m_fidx] = '0;
      m_sb[m_fidx]  = 1'b0;
      m_done        = (m_fidx == DEPTH - 1);
      if (m_done) begin
        m_flushing = 1'b0;
        m_fidx     = 0;
      end else begin
        m_fidx++;
      end
    end else begin
      m_done = 1'b0;
      if (a_if.wr_en) begin
        m_mem[a_if.wr_addr] = a_if.wr_data;
        m_sb[a_if.wr_addr]  = 1'b0;
      end
      if (a_if.rsv_en) m_sb[a_if.rsv_addr] = 1'b1;
      if (a_if.flush_req) begin
        m_flushing = 1'b1;
        m_fidx     = 0;
      end
    end
  endtask

  // Advance one clock: model commits with the inputs seen at this edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_if.rd_addr = '0; a_if.wr_en = 1'b0; a_if.wr_addr = '0; a_if.wr_data = '0;
    a_if.rsv_en = 1'b0; a_if.rsv_addr = '0; a_if.flush_req = 1'b0;
    b_if.rd_addr = '0; b_if.wr_en = 1'b0; b_if.wr_addr = '0; b_if.wr_data = '0;
    b_if.rsv_en = 1'b0; b_if.rsv_addr = '0; b_if.flush_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    clr_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (a_if.flush_busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_flush_busy got=%b exp=0", a_if.flush_busy);
    end
    n_checks++;
    if (a_if.flush_done !== 1'b0) begin
      n_errors++; $display("FAIL reset_flush_done got=%b exp=0", a_if.flush_done);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      a_if.rd_addr = {AW'(a + 1), AW'(a)};
      #1;
      n_checks++;
      if (a_if.rd_data !== '0 || a_if.rd_busy !== 2'b00) begin
        n_errors++;
        $display("FAIL reset_entries a=%0d got=%h busy=%b exp=0", a, a_if.rd_data, a_if.rd_busy);
      end
    end
    // Bypass is live while clear is held, but the write itself is dropped.
    a_if.wr_en = 1'b1; a_if.wr_addr = 3'd4; a_if.wr_data = 32'hA5A5_0004;
    a_if.rd_addr = {3'd1, 3'd4};
    #1;
    n_checks++;
    if (a_if.rd_data[31:0] !== 32'hA5A5_0004) begin
      n_errors++; $display("FAIL reset_bypass got=%h exp=a5a50004", a_if.rd_data[31:0]);
    end
    tick();
    a_if.wr_en = 1'b0;
    clr_n = 1'b1;
    #1;
    n_checks++;
    if (a_if.rd_data[31:0] !== 32'h0) begin
      n_errors++; $display("FAIL reset_write_dropped got=%h exp=0", a_if.rd_data[31:0]);
    end
    tick();
  endtask

  task automatic test_bypass();
    a_if.wr_en = 1'b1; a_if.wr_addr = 3'd3; a_if.wr_data = 32'hDEAD_BEEF;
    a_if.rd_addr = {3'd0, 3'd3};
    #1;
    n_checks++;
    if (a_if.rd_data[31:0] !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL bypass_same_cycle got=%h exp=deadbeef", a_if.rd_data[31:0]);
    end
    tick();
    a_if.wr_en = 1'b0;
    #1;
    n_checks++;
    if (a_if.rd_data[31:0] !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL bypass_stored got=%h exp=deadbeef", a_if.rd_data[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    a_if.rsv_en = 1'b1; a_if.rsv_addr = 3'd5;
    tick();
    a_if.rsv_en = 1'b0;
    a_if.rd_addr = {3'd5, 3'd0};
    #1;
    n_checks++;
    if (a_if.rd_busy[1] !== 1'b1) begin
      n_errors++; $display("FAIL sb_reserved got=%b exp=1", a_if.rd_busy[1]);
    end
    a_if.wr_en = 1'b1; a_if.wr_addr = 3'd5; a_if.wr_data = 32'h12;
    #1;
    n_checks++;
    if (a_if.rd_busy[1] !== 1'b0 || a_if.rd_data[63:32] !== 32'h12) begin
      n_errors++;
      $display("FAIL sb_writeback_same got busy=%b data=%h exp busy=0 data=12",
               a_if.rd_busy[1], a_if.rd_data[63:32]);
    end
    tick();
    a_if.wr_en = 1'b0;
    #1;
    n_checks++;
    if (a_if.rd_busy[1] !== 1'b0 || a_if.rd_data[63:32] !== 32'h12) begin
      n_errors++;
      $display("FAIL sb_writeback_after got busy=%b data=%h exp busy=0 data=12",
               a_if.rd_busy[1], a_if.rd_data[63:32]);
    end
  endtask

  task automatic test_rsv_wr_same();
    a_if.rsv_en = 1'b1; a_if.rsv_addr = 3'd2;
    a_if.wr_en = 1'b1; a_if.wr_addr = 3'd2; a_if.wr_data = 32'h7;
    tick();
    a_if.rsv_en = 1'b0; a_if.wr_en = 1'b0;
    a_if.rd_addr = {3'd2, 3'd2};
    #1;
    n_checks++;
    if (a_if.rd_data[31:0] !== 32'h7 || a_if.rd_busy !== 2'b11) begin
      n_errors++;
      $display("FAIL rsv_wr_same got data=%h busy=%b exp data=7 busy=11",
               a_if.rd_data[31:0], a_if.rd_busy);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < DEPTH; i++) begin
      a_if.wr_en = 1'b1; a_if.wr_addr = AW'(i); a_if.wr_data = DATA_W'(i + 1);
      tick();
    end
    a_if.wr_en = 1'b0;
    a_if.flush_req = 1'b1;
    #1;
    n_checks++;
    if (a_if.flush_busy !== 1'b0) begin
      n_errors++; $display("FAIL flush_busy_req_cycle got=%b exp=0", a_if.flush_busy);
    end
    tick();
    a_if.flush_req = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      a_if.rd_addr = {AW'(k == 0 ? DEPTH - 1 : k - 1), AW'(k)};
      if (k == 2) begin
        a_if.wr_en = 1'b1; a_if.wr_addr = 3'd7; a_if.wr_data = 32'hBAD;
        a_if.rsv_en = 1'b1; a_if.rsv_addr = 3'd6; a_if.flush_req = 1'b1;
      end
      #1;
      n_checks++;
      if (a_if.flush_busy !== 1'b1 || a_if.flush_done !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_status k=%0d got busy=%b done=%b exp busy=1 done=0",
                 k, a_if.flush_busy, a_if.flush_done);
      end
      n_checks++;
      if (a_if.rd_data[31:0] !== DATA_W'(k + 1) ||
          a_if.rd_data[63:32] !== DATA_W'(k == 0 ? DEPTH : 0)) begin
        n_errors++;
        $display("FAIL flush_order k=%0d got cur=%h prev=%h exp cur=%h prev=%h", k,
                 a_if.rd_data[31:0], a_if.rd_data[63:32], k + 1, (k == 0 ? DEPTH : 0));
      end
      if (k == 2) begin
        a_if.rd_addr = {3'd7, 3'd2};
        #1;
        n_checks++;
        if (a_if.rd_data[63:32] !== 32'h8 || a_if.rd_busy[1] !== 1'b0) begin
          n_errors++;
          $display("FAIL flush_no_bypass got data=%h busy=%b exp data=8 busy=0",
                   a_if.rd_data[63:32], a_if.rd_busy[1]);
        end
      end
      tick();
      a_if.wr_en = 1'b0; a_if.rsv_en = 1'b0; a_if.flush_req = 1'b0;
    end
    #1;
    n_checks++;
    if (a_if.flush_done !== 1'b1 || a_if.flush_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_done_pulse got done=%b busy=%b exp done=1 busy=0",
               a_if.flush_done, a_if.flush_busy);
    end
    tick();
    n_checks++;
    if (a_if.flush_done !== 1'b0) begin
      n_errors++; $display("FAIL flush_done_single got=%b exp=0", a_if.flush_done);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      a_if.rd_addr = {AW'(a + 1), AW'(a)};
      #1;
      n_checks++;
      if (a_if.rd_data !== '0 || a_if.rd_busy !== 2'b00) begin
        n_errors++;
        $display("FAIL flush_cleared a=%0d got=%h busy=%b exp=0", a, a_if.rd_data, a_if.rd_busy);
      end
    end
  endtask

  task automatic test_zero_reg();
    b_if.wr_en = 1'b1; b_if.wr_addr = 3'd0; b_if.wr_data = 32'hFFFF;
    b_if.rd_addr = {3'd1, 3'd0};
    #1;
    n_checks++;
    if (b_if.rd_data[31:0] !== 32'h0) begin
      n_errors++; $display("FAIL zero_no_bypass got=%h exp=0", b_if.rd_data[31:0]);
    end
    tick();
    b_if.wr_en = 1'b0;
    b_if.rsv_en = 1'b1; b_if.rsv_addr = 3'd0;
    tick();
    b_if.rsv_en = 1'b0;
    #1;
    n_checks++;
    if (b_if.rd_data[31:0] !== 32'h0 || b_if.rd_busy[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_entry got data=%h busy=%b exp data=0 busy=0",
               b_if.rd_data[31:0], b_if.rd_busy[0]);
    end
    b_if.wr_en = 1'b1; b_if.wr_addr = 3'd1; b_if.wr_data = 32'h55;
    b_if.rsv_en = 1'b1; b_if.rsv_addr = 3'd1;
    tick();
    b_if.wr_en = 1'b0; b_if.rsv_en = 1'b0;
    #1;
    n_checks++;
    if (b_if.rd_data[63:32] !== 32'h55 || b_if.rd_busy[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_other_entry got data=%h busy=%b exp data=55 busy=1",
               b_if.rd_data[63:32], b_if.rd_busy[1]);
    end
  endtask

  task automatic test_reset_during_flush();
    for (int i = 0; i < DEPTH; i++) begin
      a_if.wr_en = 1'b1; a_if.wr_addr = AW'(i); a_if.wr_data = $urandom | 32'h1;
      a_if.rsv_en = 1'b1; a_if.rsv_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
    end
    a_if.wr_en = 1'b0; a_if.rsv_en = 1'b0;
    a_if.flush_req = 1'b1;
    tick();
    a_if.flush_req = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_checks++;
    if (a_if.flush_busy !== 1'b1) begin
      n_errors++; $display("FAIL rdf_busy_before got=%b exp=1", a_if.flush_busy);
    end
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    #1;
    n_checks++;
    if (a_if.flush_busy !== 1'b0 || a_if.flush_done !== 1'b0) begin
      n_errors++;
      $display("FAIL rdf_status got busy=%b done=%b exp busy=0 done=0",
               a_if.flush_busy, a_if.flush_done);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      a_if.rd_addr = {AW'(a + 1), AW'(a)};
      #1;
      n_checks++;
      if (a_if.rd_data !== '0 || a_if.rd_busy !== 2'b00) begin
        n_errors++;
        $display("FAIL rdf_cleared a=%0d got=%h busy=%b exp=0", a, a_if.rd_data, a_if.rd_busy);
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (a_if.flush_done !== 1'b0 || a_if.flush_busy !== 1'b0) begin
        n_errors++;
        $display("FAIL rdf_quiet c=%0d got done=%b busy=%b exp 0 0",
                 c, a_if.flush_done, a_if.flush_busy);
      end
    end
  endtask

  task automatic test_random();
    int ra0, ra1;
    for (int c = 0; c < 400; c++) begin
      clr_n          = ($urandom_range(0, 49) != 0);
      a_if.wr_en     = $urandom_range(0, 1) == 1;
      a_if.wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      a_if.wr_data   = $urandom;
      a_if.rsv_en    = $urandom_range(0, 2) == 0;
      a_if.rsv_addr  = AW'($urandom_range(0, DEPTH - 1));
      a_if.flush_req = $urandom_range(0, 39) == 0;
      ra0 = $urandom_range(0, DEPTH - 1);
      ra1 = (c % 4 == 0) ? int'(a_if.wr_addr) : $urandom_range(0, DEPTH - 1);
      a_if.rd_addr = {AW'(ra1), AW'(ra0)};
      #1;
      n_checks++;
      if (a_if.rd_data[31:0] !== exp_data(ra0) || a_if.rd_busy[0] !== exp_busy(ra0)) begin
        n_errors++;
        $display("FAIL rnd_port0 c=%0d a=%0d got=%h/%b exp=%h/%b", c, ra0,
                 a_if.rd_data[31:0], a_if.rd_busy[0], exp_data(ra0), exp_busy(ra0));
      end
      n_checks++;
      if (a_if.rd_data[63:32] !== exp_data(ra1) || a_if.rd_busy[1] !== exp_busy(ra1)) begin
        n_errors++;
        $display("FAIL rnd_port1 c=%0d a=%0d got=%h/%b exp=%h/%b", c, ra1,
                 a_if.rd_data[63:32], a_if.rd_busy[1], exp_data(ra1), exp_busy(ra1));
      end
      n_checks++;
      if (a_if.flush_busy !== m_flushing || a_if.flush_done !== m_done) begin
        n_errors++;
        $display("FAIL rnd_flush c=%0d got busy=%b done=%b exp busy=%b done=%b", c,
                 a_if.flush_busy, a_if.flush_done, m_flushing, m_done);
      end
      tick();
    end
    clr_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_sb[i]  = 1'b0;
    end
    m_flushing = 1'b0;
    m_fidx     = 0;
    m_done     = 1'b0;
    clr_n      = 1'b0;
    idle_inputs();

    test_reset();
    test_bypass();
    test_scoreboard();
    test_rsv_wr_same();
    test_flush();
    test_zero_reg();
    test_reset_during_flush();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
